load_store_unit: RTL

//   Core-side initiator for the word-organised data memory (word-indexed A, combinational RD, WE/WD written on posedge clk).

---
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: RV32I byte/half/word accesses to a word-organised data memory,
// with read-modify-write for sub-word stores and access error detection.
module load_store_unit #(
    parameter int unsigned WORD_ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam int unsigned IW = WORD_ADDR_BITS;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t        state_q, state_d;

    // Latched request fields
    logic          we_q;
    logic [2:0]    f3_q;
    logic [1:0]    lane_q;
    logic [IW-1:0] idx_q;
    logic [15:0]   wdata_q;

    logic          accept;
    logic          acc_err;
    logic [31:0]   load_ext;
    logic [31:0]   merged;

    logic          req_ready_d, rsp_valid_d, rsp_err_d, mem_we_d;
    logic [31:0]   rsp_rdata_d, mem_a_d, mem_wd_d;

    assign accept = (state_q == IDLE) && req_valid;

    // Access error classification on the incoming request
    always_comb begin
        logic misaligned, illegal, out_of_range;
        misaligned   = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
        illegal      = req_we ? (req_funct3 > 3'd2)
                              : ((req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7));
        out_of_range = ((req_addr >> (IW + 2)) != 32'd0);
        acc_err      = misaligned || illegal || out_of_range;
    end

    // Load alignment and sign/zero extension from the memory word
    always_comb begin
        logic [31:0] shifted;
        shifted = mem_rd >> {lane_q, 3'b000};
        case (f3_q)
            3'd0:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    load_ext = {24'd0, shifted[7:0]};
            3'd5:    load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Sub-word store merge into the word just read
    always_comb begin
        merged = mem_rd;
        if (f3_q[0]) merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        else         merged[{lane_q, 3'b000} +: 8]      = wdata_q[7:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state and next output values
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata;
        mem_we_d    = 1'b0;
        mem_a_d     = 32'd0;
        mem_wd_d    = 32'd0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (acc_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else if (req_we && (req_funct3 == 3'd2)) begin
                        state_d  = WR;
                        mem_we_d = 1'b1;
                        mem_a_d  = 32'(req_addr[IW+1:2]);
                        mem_wd_d = req_wdata;
                    end else begin
                        state_d = RD;
                        mem_a_d = 32'(req_addr[IW+1:2]);
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    state_d  = WR;
                    mem_we_d = 1'b1;
                    mem_a_d  = 32'(idx_q);
                    mem_wd_d = merged;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_ext;
                end
            end
            WR: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = 32'd0;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            mem_we    <= 1'b0;
            mem_a     <= 32'd0;
            mem_wd    <= 32'd0;
        end else begin
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            mem_we    <= mem_we_d;
            mem_a     <= mem_a_d;
            mem_wd    <= mem_wd_d;
        end
    end

    // Request latch on accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            lane_q  <= 2'd0;
            idx_q   <= '0;
            wdata_q <= 16'd0;
        end else if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            lane_q  <= req_addr[1:0];
            idx_q   <= req_addr[IW+1:2];
            wdata_q <= req_wdata[15:0];
        end
    end

endmodule
